core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
Multi-cycle control FSM that sequences the non-pipelined RV32IM core through the fetch, decode, execute, memory and writeback stages. It issues a one-cycle enable pulse to each stage and waits for that stage's completed flag before moving on. It skips the memory stage for non-memory instructions and halts on ecall/ebreak. It also keeps cycle/retire counters and a stall watchdog. It sits in the core top level between the stage modules and the start/stop control.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles waiting for a stage completed before error (>=2)
CNT_W, 64, width of cycle and instret counters

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
start  in  1  level; begin/continue execution from IDLE
stop  in  1  level; finish current instruction, then return to IDLE
fetch_done  in  1  fetch stage completed
decode_done  in  1  decode stage completed
exec_done  in  1  execute stage completed (multi-cycle for mul/div)
mem_done  in  1  memory stage completed
wb_done  in  1  writeback stage completed
is_load  in  1  decoded flag, valid when decode_done=1
is_store  in  1  decoded flag, valid when decode_done=1
is_halt  in  1  decoded ecall|ebreak, valid when decode_done=1
fetch_en  out  1  one-cycle start pulse to fetch
decode_en  out  1  one-cycle start pulse to decode
exec_en  out  1  one-cycle start pulse to execute
mem_en  out  1  one-cycle start pulse to memory
wb_en  out  1  one-cycle start pulse to writeback
state  out  3  current seq_state_t
busy  out  1  state not in {IDLE, HALT, ERROR}
halted  out  1  state==HALT
err  out  1  state==ERROR
err_stage  out  3  state in which the timeout occurred; 0 until an error
cycle_cnt  out  CNT_W  cycles spent while busy
instret  out  CNT_W  retired instructions

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE.
  - All *_en=0; err_stage=0; cycle_cnt=0; instret=0.
  - Latched flags mem_req=0, halt_req=0, stop_req=0.
  - Reset mid-instruction aborts immediately. No pulse is issued in the reset cycle.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- Enable pulse rule:
  - The cycle a stage state is entered, its *_en=1 for exactly that cycle; it is 0 in all later cycles of the state.
  - The done input is ignored in the entry cycle. Stages mask completed while enabled, so a stale done must not advance the FSM.
  - done is sampled only from the second cycle of the state onward.
  - When done=1, the next state is entered at the next posedge.
  - Minimum 2 cycles per stage: 8 cycles/instruction without MEM, 10 with MEM.
- Transitions:
  - IDLE -> FETCH when start=1 and stop=0.
  - FETCH -> DECODE on fetch_done.
  - DECODE -> EXEC on decode_done. In the same cycle, latch mem_req=is_load|is_store and halt_req=is_halt.
  - EXEC -> MEM on exec_done if mem_req, else EXEC -> WB.
  - MEM -> WB on mem_done.
  - WB: on wb_done, instret+=1. Next state:
    - HALT if halt_req;
    - else IDLE if stop_req or stop=1;
    - else FETCH.
  - HALT and ERROR are sticky; only reset leaves them. start is ignored there.
- stop:
  - stop=1 in any busy state sets stop_req.
  - stop_req clears on entering IDLE.
  - The instruction in flight always completes; no stage is abandoned.
- Watchdog:
  - Counter clears on every stage entry and increments each cycle while waiting.
  - If TIMEOUT_CYCLES cycles have elapsed since entry without done, go to ERROR next cycle and set err_stage=state. done arriving in that same cycle wins (normal transition).
- Counters:
  - cycle_cnt increments every cycle busy=1.
  - Both counters wrap modulo 2^CNT_W with no saturation.
- Simultaneous events:
  - wb_done with halt_req and stop=1 -> HALT (halt has priority).
  - A done on a non-current stage is ignored.

Decomposition:
- Package core_pkg holds:
  - typedef enum logic[2:0] seq_state_t {IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7};
  - default TIMEOUT_CYCLES constant.
- Sub-module seq_watchdog: clear input, count-enable input, timeout output, parameter TIMEOUT_CYCLES.
- FSM, pulse generation and counters stay in core_sequencer.

Test Plan:
- ALU instruction: start=1; every stage's done asserted 1 cycle after its en. Expect en pulses at cycles 1,3,5,7 (FETCH, DECODE, EXEC, WB), no mem_en, instret=1 at cycle 9, then fetch_en again.
- Load instruction: is_load=1 with decode_done. Expect mem_en between exec and wb, 10 cycles/instruction; instret=3 after 30 cycles of 3 back-to-back loads.
- Stale done: hold exec_done=1 continuously. FSM must still spend exactly 2 cycles in EXEC and must not skip it; each *_en is high exactly 1 cycle per entry.
- Halt: is_halt=1 at decode; stop=1 asserted simultaneously with wb_done. Expect state=HALT, halted=1; start ignored for 20 cycles; busy=0.
- Watchdog: TIMEOUT_CYCLES=16, mem_done never asserted. Expect ERROR 17 cycles after MEM entry, err=1, err_stage=4. A second run with mem_done exactly on the timeout cycle must reach WB with no error.
- Reset mid-EXEC: rstn=0 for 1 cycle. Expect state=IDLE, all counters 0, no en pulse; restart with start=1 produces fetch_en.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and defaults for the RV32IM multi-cycle core control path.
// The sequencer state encoding is also visible on the core's debug port.
package core_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6,
      ERROR  = 3'd7
   } seq_state_t;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;
   localparam int unsigned CNT_W_DEFAULT          = 64;

   // True for the five instruction stages, i.e. while an instruction is in flight.
   function automatic logic is_stage(seq_state_t s);
      logic r;
      case (s)
         FETCH, DECODE, EXEC, MEM, WB: r = 1'b1;
         default:                      r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Stall watchdog: counts cycles spent waiting on a stage's completed flag
// and flags a timeout once TIMEOUT_CYCLES cycles have passed since entry.
module seq_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic count_en,
   output logic timeout
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   // cnt holds (waiting cycles - 1); it saturates so a stuck stage never wraps past the limit
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (count_en && (cnt != LIMIT)) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign timeout = count_en && (cnt == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the non-pipelined RV32IM core: pulses each
// stage enable, waits for its completed flag, and keeps cycle/retire counts.
module core_sequencer
   import core_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter int unsigned CNT_W          = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             stop,
   input  logic             fetch_done,
   input  logic             decode_done,
   input  logic             exec_done,
   input  logic             mem_done,
   input  logic             wb_done,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             is_halt,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             mem_en,
   output logic             wb_en,
   output logic [2:0]       state,
   output logic             busy,
   output logic             halted,
   output logic             err,
   output logic [2:0]       err_stage,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret
);

   seq_state_t       state_q, state_d;
   logic             first_q;
   logic             mem_req_q, mem_req_d;
   logic             halt_req_q, halt_req_d;
   logic             stop_req_q, stop_req_d;
   logic [2:0]       err_stage_q, err_stage_d;
   logic [CNT_W-1:0] cycle_cnt_q, instret_q;
   logic             in_stage;
   logic             done_cur;
   logic             done_seen;
   logic             retire;
   logic             timeout;

   assign in_stage = is_stage(state_q);

   // Completed flag of the stage we are in; other stages' flags are ignored.
   always_comb begin
      done_cur = 1'b0;
      case (state_q)
         FETCH:   done_cur = fetch_done;
         DECODE:  done_cur = decode_done;
         EXEC:    done_cur = exec_done;
         MEM:     done_cur = mem_done;
         WB:      done_cur = wb_done;
         default: done_cur = 1'b0;
      endcase
   end

   // The entry cycle carries the enable pulse, so a done seen then is stale.
   assign done_seen = in_stage && !first_q && done_cur;

   seq_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (first_q),
      .count_en (in_stage && !first_q),
      .timeout  (timeout)
   );

   // Next-state and latched request flags
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      halt_req_d  = halt_req_q;
      stop_req_d  = stop_req_q;
      err_stage_d = err_stage_q;
      retire      = 1'b0;

      if (in_stage && stop) begin
         stop_req_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start && !stop) state_d = FETCH;
         end
         FETCH: begin
            if (done_seen) state_d = DECODE;
         end
         DECODE: begin
            if (done_seen) begin
               state_d    = EXEC;
               mem_req_d  = is_load | is_store;
               halt_req_d = is_halt;
            end
         end
         EXEC: begin
            if (done_seen) state_d = mem_req_q ? MEM : WB;
         end
         MEM: begin
            if (done_seen) state_d = WB;
         end
         WB: begin
            if (done_seen) begin
               retire = 1'b1;
               if (halt_req_q)             state_d = HALT;
               else if (stop_req_q || stop) state_d = IDLE;
               else                        state_d = FETCH;
            end
         end
         default: state_d = state_q;
      endcase

      // A done arriving on the timeout cycle still wins.
      if (timeout && !done_seen) begin
         state_d     = ERROR;
         err_stage_d = state_q;
      end

      if ((state_d == IDLE) && (state_q != IDLE)) begin
         stop_req_d = 1'b0;
      end
   end

   // State register, entry marker and counters
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         first_q     <= 1'b0;
         mem_req_q   <= 1'b0;
         halt_req_q  <= 1'b0;
         stop_req_q  <= 1'b0;
         err_stage_q <= 3'd0;
         cycle_cnt_q <= '0;
         instret_q   <= '0;
      end else begin
         state_q     <= state_d;
         first_q     <= (state_d != state_q);
         mem_req_q   <= mem_req_d;
         halt_req_q  <= halt_req_d;
         stop_req_q  <= stop_req_d;
         err_stage_q <= err_stage_d;
         if (in_stage) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
         if (retire)   instret_q   <= instret_q + CNT_W'(1);
      end
   end

   assign fetch_en  = first_q && (state_q == FETCH);
   assign decode_en = first_q && (state_q == DECODE);
   assign exec_en   = first_q && (state_q == EXEC);
   assign mem_en    = first_q && (state_q == MEM);
   assign wb_en     = first_q && (state_q == WB);

   assign state     = state_q;
   assign busy      = in_stage;
   assign halted    = (state_q == HALT);
   assign err       = (state_q == ERROR);
   assign err_stage = err_stage_q;
   assign cycle_cnt = cycle_cnt_q;
   assign instret   = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: per-cycle vector table through a scoreboard queue,
// plus hand sequences for mid-instruction reset and the stall watchdog.
module tb_core_sequencer;
   import core_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [4:0]  done_v = '0;
   logic        is_load = 1'b0, is_store = 1'b0, is_halt = 1'b0;
   logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
   logic [2:0]  state;
   logic        busy, halted, err;
   logic [2:0]  err_stage;
   logic [63:0] cycle_cnt, instret;

   core_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(64)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .stop        (stop),
      .fetch_done  (done_v[0]),
      .decode_done (done_v[1]),
      .exec_done   (done_v[2]),
      .mem_done    (done_v[3]),
      .wb_done     (done_v[4]),
      .is_load     (is_load),
      .is_store    (is_store),
      .is_halt     (is_halt),
      .fetch_en    (fetch_en),
      .decode_en   (decode_en),
      .exec_en     (exec_en),
      .mem_en      (mem_en),
      .wb_en       (wb_en),
      .state       (state),
      .busy        (busy),
      .halted      (halted),
      .err         (err),
      .err_stage   (err_stage),
      .cycle_cnt   (cycle_cnt),
      .instret     (instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        stop;
      logic [4:0]  done;
      logic        ld;
      logic        sto;
      logic        hl;
      seq_state_t  st;
      logic [4:0]  en;
      longint unsigned ir;
      longint unsigned cyc;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   checks = 0;
   int   errors = 0;
   longint unsigned gen_ir = 0;
   longint unsigned gen_cyc = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic exp_busy(seq_state_t s);
      return (s == FETCH) || (s == DECODE) || (s == EXEC) || (s == MEM) || (s == WB);
   endfunction

   // One table row = inputs for a cycle and the outputs expected in that cycle.
   function automatic void add_row(logic s, logic sp, logic [4:0] d, logic ld, logic sto,
                                   logic hl, seq_state_t st, logic [4:0] en);
      vec_t v;
      v.start = s;  v.stop = sp; v.done = d;
      v.ld = ld;    v.sto = sto; v.hl = hl;
      v.st = st;    v.en = en;
      v.ir = gen_ir; v.cyc = gen_cyc;
      vecs.push_back(v);
      if (exp_busy(st)) gen_cyc++;
   endfunction

   // Appends the rows of one instruction, starting with the FETCH entry cycle.
   function automatic void gen_instr(logic ld, logic sto, logic hl, logic stale,
                                     int wait_n, logic stop_mid, logic stop_end);
      seq_state_t stg[$];
      stg.push_back(FETCH);
      stg.push_back(DECODE);
      stg.push_back(EXEC);
      if (ld || sto) stg.push_back(MEM);
      stg.push_back(WB);
      foreach (stg[k]) begin
         seq_state_t s;
         logic [4:0] own;
         logic [4:0] base;
         s    = stg[k];
         own  = 5'(1 << (int'(s) - 1));
         base = stale ? 5'b11111 : 5'b00000;
         add_row(1'b0, stop_mid && (s == FETCH), base, 1'b0, 1'b0, 1'b0, s, own);
         if (!stale) begin
            for (int w = 0; w < wait_n; w++)
               add_row(1'b0, 1'b0, ~own, 1'b0, 1'b0, 1'b0, s, 5'b00000);
         end
         add_row(1'b0, stop_end && (s == WB), base | own,
                 ld && (s == DECODE), sto && (s == DECODE), hl && (s == DECODE), s, 5'b00000);
      end
      gen_ir++;
   endfunction

   task automatic adv(int idx);
      done_v[idx] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      done_v[idx] = 1'b0;
   endtask

   function automatic logic [4:0] en_vec();
      return {wb_en, mem_en, exec_en, decode_en, fetch_en};
   endfunction

   task automatic do_reset();
      start = 1'b0; stop = 1'b0; done_v = '0;
      is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic wd_run(logic give_done);
      do_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      adv(0);
      is_load = 1'b1;
      adv(1);
      is_load = 1'b0;
      adv(2);
      chk("wd mem entry state", 64'(state), 64'(MEM));
      chk("wd mem entry en", 64'(mem_en), 64'd1);
      repeat (TO) @(negedge clk);
      chk("wd state at limit", 64'(state), 64'(MEM));
      if (give_done) done_v[3] = 1'b1;
      @(negedge clk);
      done_v[3] = 1'b0;
      if (give_done) begin
         chk("wd late done state", 64'(state), 64'(WB));
         chk("wd late done wb_en", 64'(wb_en), 64'd1);
         chk("wd late done err", 64'(err), 64'd0);
      end else begin
         chk("wd timeout state", 64'(state), 64'(ERROR));
         chk("wd timeout err", 64'(err), 64'd1);
         chk("wd timeout err_stage", 64'(err_stage), 64'd4);
         chk("wd timeout busy", 64'(busy), 64'd0);
         start = 1'b1;
         repeat (3) @(negedge clk);
         chk("wd error sticky", 64'(state), 64'(ERROR));
         chk("wd error no fetch_en", 64'(fetch_en), 64'd0);
         start = 1'b0;
      end
   endtask

   initial begin
      vec_t e;

      // Vector table
      add_row(1'b1, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, IDLE, 5'b0);
      gen_instr(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // ALU
      gen_instr(1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1);   // load, stop with wb_done
      add_row(1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, IDLE, 5'b0);
      add_row(1'b1, 1'b1, 5'b0, 1'b0, 1'b0, 1'b0, IDLE, 5'b0);
      add_row(1'b1, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, IDLE, 5'b0);
      gen_instr(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // load
      gen_instr(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);   // store, all done flags held high
      gen_instr(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);   // load, stop early in FETCH
      add_row(1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, IDLE, 5'b0);
      add_row(1'b1, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, IDLE, 5'b0);
      gen_instr(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);   // ecall, stop with wb_done
      for (int i = 0; i < 20; i++)
         add_row(1'b1, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, HALT, 5'b0);

      // Reset state
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset state", 64'(state), 64'(IDLE));
      chk("reset en", 64'(en_vec()), 64'd0);
      chk("reset cycle_cnt", cycle_cnt, 64'd0);
      chk("reset instret", instret, 64'd0);
      chk("reset err_stage", 64'(err_stage), 64'd0);
      rstn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         start    = vecs[i].start;
         stop     = vecs[i].stop;
         done_v   = vecs[i].done;
         is_load  = vecs[i].ld;
         is_store = vecs[i].sto;
         is_halt  = vecs[i].hl;
         sb.push_back(vecs[i]);
         #1;
         e = sb.pop_front();
         chk($sformatf("row%0d state", i), 64'(state), 64'(e.st));
         chk($sformatf("row%0d en", i), 64'(en_vec()), 64'(e.en));
         chk($sformatf("row%0d instret", i), instret, 64'(e.ir));
         chk($sformatf("row%0d cycle_cnt", i), cycle_cnt, 64'(e.cyc));
         chk($sformatf("row%0d busy", i), 64'(busy), 64'(exp_busy(e.st)));
         chk($sformatf("row%0d halted", i), 64'(halted), 64'(e.st == HALT));
         chk($sformatf("row%0d err", i), 64'(err), 64'd0);
         @(negedge clk);
      end
      chk("halt err_stage", 64'(err_stage), 64'd0);

      // Reset in the middle of EXEC
      do_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("rst seq fetch_en", 64'(fetch_en), 64'd1);
      adv(0);
      adv(1);
      @(negedge clk);
      chk("rst seq in exec", 64'(state), 64'(EXEC));
      chk("rst seq cycle_cnt", cycle_cnt, 64'd5);
      rstn = 1'b0;
      @(negedge clk);
      chk("mid reset state", 64'(state), 64'(IDLE));
      chk("mid reset en", 64'(en_vec()), 64'd0);
      chk("mid reset cycle_cnt", cycle_cnt, 64'd0);
      chk("mid reset instret", instret, 64'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("post reset idle", 64'(state), 64'(IDLE));
      chk("post reset no pulse", 64'(en_vec()), 64'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart state", 64'(state), 64'(FETCH));
      chk("restart fetch_en", 64'(fetch_en), 64'd1);
      @(negedge clk);
      chk("restart fetch_en drops", 64'(fetch_en), 64'd0);

      // Watchdog: no done, then done exactly on the limit cycle
      wd_run(1'b0);
      wd_run(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
